// File: rtl/median_window_sequencer.sv
// Sequences one 3x3 median window: load pixels, run the sort engine, wait out the pipeline, present the result.
// Latency: 1 + SORT_CYCLES + PIPE_LAT cycles from the last pixel accept to out_valid (12 at default parameters).
// Backpressure: in_ready is high only in LOAD; out_valid is held until out_ready, with no window overlap.
// Optional build macro MEDIAN_SEQ_PERF_EN adds saturating window and output-stall counters.
module median_window_sequencer #(
    parameter int WINDOW_SIZE = 9,
    parameter int SORT_CYCLES = 9,
    parameter int PIPE_LAT    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        load_en,
    output logic [3:0]  counter_window,
    output logic [3:0]  delayed_counter_window,
    output logic        start_bubble_sort,
    output logic        delay_start_bubble_sort,
    output logic        delay_2clk_start_bubble_sort,
    output logic        sort_en,
    output logic [3:0]  sort_step,
    output logic        sort_phase,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] win_count,
    output logic [15:0] stall_count
);

    // Terminal values of the 4-bit counters, computed once so the compares stay width-exact.
    localparam logic [3:0] LP_CW_LAST   = 4'(WINDOW_SIZE - 1);
    localparam logic [3:0] LP_SORT_LAST = 4'(SORT_CYCLES - 1);
    localparam logic [3:0] LP_WAIT_LAST = (PIPE_LAT == 0) ? 4'd0 : 4'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SORT = 3'd2,
        S_WAIT = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t     r_state;
    logic [3:0] r_counter_window;
    logic [3:0] r_delayed_counter_window;
    logic       r_start_bubble_sort;
    logic       r_delay_start;
    logic       r_delay_2clk_start;
    logic       r_sort_en;
    logic [3:0] r_sort_step;
    logic [3:0] r_wait_cnt;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       r_busy;

    logic       w_accept;
    logic       w_handshake;

    // A pixel beat is written whenever upstream and sequencer agree, even if a flush discards it.
    assign w_accept    = in_valid & r_in_ready;
    assign w_handshake = r_out_valid & out_ready;

    // Main FSM; every control output is registered and set on the transition into its state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state                  <= S_IDLE;
            r_counter_window         <= 4'd0;
            r_delayed_counter_window <= 4'd0;
            r_start_bubble_sort      <= 1'b0;
            r_delay_start            <= 1'b0;
            r_delay_2clk_start       <= 1'b0;
            r_sort_en                <= 1'b0;
            r_sort_step              <= 4'd0;
            r_wait_cnt               <= 4'd0;
            r_in_ready               <= 1'b0;
            r_out_valid              <= 1'b0;
            r_busy                   <= 1'b0;
        end else begin
            // The datapath's delay chain runs in every state, flush included.
            r_delayed_counter_window <= r_counter_window;
            r_delay_start            <= r_start_bubble_sort;
            r_delay_2clk_start       <= r_delay_start;
            // start_bubble_sort is a single-cycle pulse unless re-armed below.
            r_start_bubble_sort      <= 1'b0;

            if (flush) begin
                // Abort wins over an accept in the same cycle; the partial window is dropped.
                r_state          <= S_IDLE;
                r_counter_window <= 4'd0;
                r_sort_step      <= 4'd0;
                r_wait_cnt       <= 4'd0;
                r_sort_en        <= 1'b0;
                r_in_ready       <= 1'b0;
                r_out_valid      <= 1'b0;
                r_busy           <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (enable) begin
                            r_state    <= S_LOAD;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end

                    S_LOAD: begin
                        if (w_accept) begin
                            if (r_counter_window == LP_CW_LAST) begin
                                // Window full: stop accepting and fire the first sort phase.
                                r_counter_window    <= 4'd0;
                                r_state             <= S_SORT;
                                r_in_ready          <= 1'b0;
                                r_sort_en           <= 1'b1;
                                r_sort_step         <= 4'd0;
                                r_start_bubble_sort <= 1'b1;
                            end else begin
                                r_counter_window <= r_counter_window + 4'd1;
                            end
                        end
                    end

                    S_SORT: begin
                        if (r_sort_step == LP_SORT_LAST) begin
                            r_sort_en   <= 1'b0;
                            r_sort_step <= 4'd0;
                            if (PIPE_LAT == 0) begin
                                r_state     <= S_OUT;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_state    <= S_WAIT;
                                r_wait_cnt <= 4'd0;
                            end
                        end else begin
                            r_sort_step <= r_sort_step + 4'd1;
                        end
                    end

                    S_WAIT: begin
                        // Let the last compare-swap drain through the datapath pipeline.
                        if (r_wait_cnt == LP_WAIT_LAST) begin
                            r_wait_cnt  <= 4'd0;
                            r_state     <= S_OUT;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 4'd1;
                        end
                    end

                    S_OUT: begin
                        // Result stays valid until taken; enable decides whether another window follows.
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            if (enable) begin
                                r_state    <= S_LOAD;
                                r_in_ready <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b0;
                        r_sort_en   <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready                     = r_in_ready;
    assign load_en                      = w_accept;
    assign counter_window               = r_counter_window;
    assign delayed_counter_window       = r_delayed_counter_window;
    assign start_bubble_sort            = r_start_bubble_sort;
    assign delay_start_bubble_sort      = r_delay_start;
    assign delay_2clk_start_bubble_sort = r_delay_2clk_start;
    assign sort_en                      = r_sort_en;
    assign sort_step                    = r_sort_step;
    assign sort_phase                   = r_sort_step[0];
    assign out_valid                    = r_out_valid;
    assign busy                         = r_busy;

`ifdef MEDIAN_SEQ_PERF_EN
    logic [15:0] r_win_count;
    logic [15:0] r_stall_count;

    // Saturating performance counters; only reset clears them, flush leaves them alone.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_win_count   <= 16'd0;
            r_stall_count <= 16'd0;
        end else begin
            if (w_handshake && (r_win_count != 16'hFFFF)) begin
                r_win_count <= r_win_count + 16'd1;
            end
            if (r_out_valid && !out_ready && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign win_count   = r_win_count;
    assign stall_count = r_stall_count;
`else
    logic w_unused;
    assign w_unused    = w_handshake;
    assign win_count   = 16'd0;
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_median_window_sequencer.sv
// Randomized and directed stimulus for median_window_sequencer against a window-level reference model.
// Latency: outputs are compared once per cycle on the falling edge.
// Backpressure: out_ready is driven both in fixed stall runs and randomly.
module tb_median_window_sequencer;

    localparam int WS = 9;
    localparam int SC = 9;
    localparam int PL = 2;

    logic        CLK;
    logic        RST;
    logic        enable;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        load_en;
    logic [3:0]  counter_window;
    logic [3:0]  delayed_counter_window;
    logic        start_bubble_sort;
    logic        delay_start_bubble_sort;
    logic        delay_2clk_start_bubble_sort;
    logic        sort_en;
    logic [3:0]  sort_step;
    logic        sort_phase;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] win_count;
    logic [15:0] stall_count;

    median_window_sequencer #(
        .WINDOW_SIZE(WS),
        .SORT_CYCLES(SC),
        .PIPE_LAT   (PL)
    ) dut (
        .CLK                         (CLK),
        .RST                         (RST),
        .enable                      (enable),
        .flush                       (flush),
        .in_valid                    (in_valid),
        .in_ready                    (in_ready),
        .load_en                     (load_en),
        .counter_window              (counter_window),
        .delayed_counter_window      (delayed_counter_window),
        .start_bubble_sort           (start_bubble_sort),
        .delay_start_bubble_sort     (delay_start_bubble_sort),
        .delay_2clk_start_bubble_sort(delay_2clk_start_bubble_sort),
        .sort_en                     (sort_en),
        .sort_step                   (sort_step),
        .sort_phase                  (sort_phase),
        .out_valid                   (out_valid),
        .out_ready                   (out_ready),
        .busy                        (busy),
        .win_count                   (win_count),
        .stall_count                 (stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks   = 0;
    int n_failures = 0;

    // Window-level model: whether a window is open, pixels gathered so far,
    // cycles elapsed since the window filled (-1 when none), and a pending result.
    bit m_active;
    bit m_loading;
    bit m_out;
    int m_pix;
    int m_t;
    int m_dcw;
    int m_ds1;
    int m_ds2;
    int m_win;
    int m_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active  = 0;
        m_loading = 0;
        m_out     = 0;
        m_pix     = 0;
        m_t       = -1;
        m_dcw     = 0;
        m_ds1     = 0;
        m_ds2     = 0;
        m_win     = 0;
        m_stall   = 0;
    endtask

    function automatic logic [31:0] dut_vec();
        return {11'd0, busy, in_ready, load_en, counter_window, delayed_counter_window,
                start_bubble_sort, delay_start_bubble_sort, delay_2clk_start_bubble_sort,
                sort_en, sort_step, sort_phase, out_valid};
    endfunction

    function automatic logic [31:0] perf_vec();
        return {win_count, stall_count};
    endfunction

    // Expected outputs for the current cycle, derived from the model's window progress.
    function automatic logic [31:0] exp_vec();
        bit         e_sort;
        bit         e_start;
        logic [3:0] e_step;
        e_sort  = (m_t >= 0) && (m_t < SC);
        e_start = (m_t == 0);
        e_step  = e_sort ? 4'(m_t) : 4'd0;
        return {11'd0, m_active, m_loading, (in_valid & m_loading), 4'(m_pix), 4'(m_dcw),
                e_start, 1'(m_ds1), 1'(m_ds2), e_sort, e_step, e_step[0], m_out};
    endfunction

    function automatic logic [31:0] exp_perf();
`ifdef MEDIAN_SEQ_PERF_EN
        return {16'(m_win), 16'(m_stall)};
`else
        return 32'd0;
`endif
    endfunction

    // Compare on the falling edge, then advance the model with this cycle's inputs.
    task automatic tick(input string tag);
        bit e_start;
        @(negedge CLK);
        check({tag, "_vec"}, dut_vec(), exp_vec());
        check({tag, "_perf"}, perf_vec(), exp_perf());
        e_start = (m_t == 0);
        m_ds2   = m_ds1;
        m_ds1   = int'(e_start);
        m_dcw   = m_pix;
        if (m_out && out_ready && m_win < 65535) m_win++;
        if (m_out && !out_ready && m_stall < 65535) m_stall++;
        if (flush) begin
            m_active  = 0;
            m_loading = 0;
            m_out     = 0;
            m_pix     = 0;
            m_t       = -1;
        end else if (!m_active) begin
            if (enable) begin
                m_active  = 1;
                m_loading = 1;
            end
        end else if (m_loading) begin
            if (in_valid) begin
                m_pix++;
                if (m_pix == WS) begin
                    m_pix     = 0;
                    m_loading = 0;
                    m_t       = 0;
                end
            end
        end else if (m_t >= 0) begin
            m_t++;
            if (m_t == SC + PL) begin
                m_t   = -1;
                m_out = 1;
            end
        end else if (m_out) begin
            if (out_ready) begin
                m_out = 0;
                if (enable) m_loading = 1;
                else        m_active  = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // One full window: pixels every (gap+1) cycles, out_ready held low for 'stall' result cycles.
    task automatic run_window(input string tag, input int gap, input int stall,
                              input bit en_after, input bit drop_in_sort);
        int stalled;
        bit done;
        bit hs;
        stalled   = 0;
        done      = 0;
        enable    = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            in_valid = ((c % (gap + 1)) == 0);
            if (drop_in_sort && m_t >= 0) enable = 1'b0;
            out_ready = 1'b0;
            if (m_out) begin
                enable = drop_in_sort ? 1'b0 : en_after;
                if (stalled < stall) stalled++;
                else out_ready = 1'b1;
            end
            hs = m_out && out_ready;
            tick(tag);
            if (hs) done = 1;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        RST       = 1'b0;
        enable    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #2;
        check("rst_vec", dut_vec(), 32'd0);
        check("rst_perf", perf_vec(), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        tick("idle0");
        tick("idle1");

        // Back-to-back window, then gapped input, then a stalled result.
        run_window("b2b", 0, 0, 1'b1, 1'b0);
        run_window("gap", 2, 0, 1'b1, 1'b0);
        run_window("bp", 0, 5, 1'b0, 1'b0);
        tick("bp_idle");

        // Flush on the fifth accept discards the window; a fresh one needs nine new pixels.
        enable   = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 20 && !(m_loading && m_pix == 4); c++) tick("fl_fill");
        check("fl_reach", 32'(m_pix), 32'd4);
        flush = 1'b1;
        tick("fl_hit");
        flush    = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        tick("fl_idle");
        run_window("fl_new", 0, 0, 1'b0, 1'b0);

        // enable drops during sort: result still delivered, then idle.
        run_window("drop", 0, 1, 1'b0, 1'b1);
        tick("drop_idle");
        tick("drop_idle2");

        // Asynchronous reset in the middle of sorting.
        enable   = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && m_t != 4; c++) tick("rs_fill");
        check("rs_reach", 32'(m_t), 32'd4);
        RST = 1'b0;
        #1;
        check("rs_vec", dut_vec(), 32'd0);
        check("rs_perf", perf_vec(), 32'd0);
        #1;
        RST      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        model_reset();
        tick("rs_idle0");
        tick("rs_idle1");
        tick("rs_idle2");

        // Random traffic with occasional flushes.
        for (int c = 0; c < 2000; c++) begin
            enable    = ($urandom_range(0, 7) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            tick("rnd");
        end
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

// File: doc/median_window_sequencer.md
Name: median_window_sequencer

Overview:
Control FSM for the 3x3 median filter datapath. It accepts 9 window pixels through a valid/ready handshake and drives the window write index (counter_window) to the window register file. It then runs the odd-even transposition sort engine for a fixed number of cycles, waits out the 2-cycle datapath pipeline, and presents the median result to the downstream stage through a valid/ready handshake. It owns the counter_window and start_bubble_sort delay chain that the datapath consumes.

Parameters:
WINDOW_SIZE, 9, pixels per window; legal range 3..15.
SORT_CYCLES, 9, compare-swap phases per window; legal range 1..15.
PIPE_LAT, 2, cycles from the last sort phase until the median is valid at the datapath output; legal range 0..3.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous reset, active-low.
enable  in  1  run request, sampled only in IDLE and at the end of a window.
flush  in  1  synchronous abort to IDLE.
in_valid  in  1  upstream pixel valid.
in_ready  out  1  sequencer can accept a pixel.
load_en  out  1  write strobe to the window register: in_valid & in_ready (combinational).
counter_window  out  4  window write index for the current beat.
delayed_counter_window  out  4  counter_window registered by 1 clock.
start_bubble_sort  out  1  1-cycle pulse in the first SORT cycle.
delay_start_bubble_sort  out  1  start_bubble_sort delayed by 1 clock.
delay_2clk_start_bubble_sort  out  1  start_bubble_sort delayed by 2 clocks.
sort_en  out  1  sort engine active.
sort_step  out  4  current phase index, 0..SORT_CYCLES-1.
sort_phase  out  1  sort_step[0]: 0 = even pairs, 1 = odd pairs.
out_valid  out  1  median available downstream.
out_ready  in  1  downstream accepts.
busy  out  1  state is not IDLE.
win_count  out  16  completed windows (MEDIAN_SEQ_PERF_EN only).
stall_count  out  16  OUT cycles with out_ready=0 (MEDIAN_SEQ_PERF_EN only).

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0. This includes counter_window, both delay-chain registers, sort_step and the counters.
- States and transitions:
  - IDLE: in_ready=0. If enable=1, go to LOAD next cycle.
  - LOAD: in_ready=1. Each accept increments counter_window. An accept with counter_window=WINDOW_SIZE-1 wraps counter_window to 0 and enters SORT. No accept means hold.
  - SORT: sort_en=1 for exactly SORT_CYCLES cycles; sort_step counts 0..SORT_CYCLES-1. start_bubble_sort=1 only when sort_step=0. After the last step, go to WAIT.
  - WAIT: hold PIPE_LAT cycles using an internal counter. PIPE_LAT=0 goes straight to OUT.
  - OUT: out_valid=1 until out_ready=1. The handshake cycle returns to LOAD if enable=1, otherwise to IDLE. out_valid must not drop without a handshake.
- The delay chain registers every cycle in all states: delayed_counter_window <= counter_window; delay_start <= start_bubble_sort; delay_2clk <= delay_start.
- flush=1 (sync) in any state: next state IDLE; counter_window, sort_step and the WAIT counter are cleared to 0; out_valid drops next cycle. flush has priority over an accept in the same cycle, so that accept's load_en still pulses but the window is discarded.
- enable dropping mid-window does not abort; the window completes and the sequencer goes to IDLE after OUT.
- in_ready is 0 in SORT, WAIT and OUT (no overlap). Latency from the last pixel accept to out_valid = 1 + SORT_CYCLES + PIPE_LAT cycles (default 12).
- All counters are width-safe at the 4-bit maximum (15); no wrap occurs except the counter_window wrap at WINDOW_SIZE-1.

Optional Feature:
MEDIAN_SEQ_PERF_EN
- Defined:
  - win_count increments on each out_valid&out_ready.
  - stall_count increments each OUT cycle with out_ready=0.
  - Both saturate at 0xFFFF and clear on reset only; flush does not clear them.
- Undefined: win_count and stall_count are tied to 0 and no counter logic is instantiated.

Test Plan:
- Reset mid-SORT (RST low at sort_step=4) -> all outputs 0 immediately; IDLE after release; in_ready=0 until enable.
- enable=1, 9 back-to-back pixels -> counter_window 0..8 then 0; start_bubble_sort pulses in the cycle after the 9th accept; delay_start and delay_2clk follow at +1 and +2 cycles; out_valid rises 12 cycles after the 9th accept.
- Gapped input (in_valid 1-of-3 cycles) -> counter_window holds during gaps; exactly 9 load_en pulses; sort starts only after the 9th.
- Backpressure: out_ready=0 for 5 cycles -> out_valid held 6 cycles; stall_count=5 and win_count=1 with MEDIAN_SEQ_PERF_EN.
- flush coinciding with the 5th accept -> IDLE next cycle; counter_window=0; a fresh window then needs 9 new accepts.
- enable deasserted during SORT -> current median delivered; after handshake the state is IDLE and busy=0.
